// File: rtl/riscv_br_pkg.sv
// ============================================================================
// riscv_br_pkg : shared types and constants for the branch redirect slice
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package riscv_br_pkg;

    localparam int XLEN        = 32;
    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        BR_BEQ  = 2'b00,
        BR_BNE  = 2'b01,
        BR_JAL  = 2'b10,
        BR_JALR = 2'b11
    } br_op_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } br_state_t;

endpackage

`default_nettype wire

// File: rtl/branch_redirect_ctrl_br_cond.sv
// ============================================================================
// br_cond : decides branch taken from the opcode and the equality flag
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module br_cond (
    input  logic [1:0] BrOp,
    input  logic       BrRes,
    output logic       taken
);
    import riscv_br_pkg::*;

    always_comb begin
        taken = 1'b0;
        case (BrOp)
            BR_BEQ:  taken = BrRes;
            BR_BNE:  taken = ~BrRes;
            BR_JAL:  taken = 1'b1;
            BR_JALR: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
// ============================================================================
// branch_redirect_ctrl : fetch PC owner, taken-branch redirect and flush window
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module branch_redirect_ctrl #(
    parameter int               XLEN         = riscv_br_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC     = '0,
    parameter int               FLUSH_CYCLES = 2,
    parameter int               CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Stall,
    input  logic             BrValid,
    input  logic [1:0]       BrOp,
    input  logic             BrRes,
    input  logic [XLEN-1:0]  BrTarget,
    output logic [XLEN-1:0]  PC,
    output logic             Taken,
    output logic             Flush,
    output logic             BrBusy,
    output logic [CNT_W-1:0] TakenCnt
);
    import riscv_br_pkg::*;

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

    br_state_t              state_q, state_d;
    logic [XLEN-1:0]        pc_q, pc_d;
    logic                   taken_q, taken_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FLUSH_CNT_W-1:0] fcnt_q, fcnt_d;
    logic                   cond_taken;
    logic [XLEN-1:0]        pc_inc;
    logic [XLEN-1:0]        eff_target;

    br_cond u_br_cond (
        .BrOp  (BrOp),
        .BrRes (BrRes),
        .taken (cond_taken)
    );

    assign pc_inc     = pc_q + XLEN'(4);
    // JALR clears bit 0 only; bit 1 misalignment is left to a later stage
    assign eff_target = {BrTarget[XLEN-1:1], BrTarget[0] & (BrOp != BR_JALR)};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = 1'b0;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        if (!Stall) begin
            case (state_q)
                RUN: begin
                    if (BrValid && cond_taken) begin
                        pc_d    = eff_target;
                        taken_d = 1'b1;
                        fcnt_d  = FLUSH_LOAD;
                        state_d = FLUSH;
                        if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        pc_d = pc_inc;
                    end
                end
                FLUSH: begin
                    // BrValid here belongs to the wrong path and is ignored
                    pc_d   = pc_inc;
                    fcnt_d = fcnt_q - FLUSH_CNT_W'(1);
                    if (fcnt_q == FLUSH_CNT_W'(1)) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign PC       = pc_q;
    assign Taken    = taken_q;
    assign Flush    = (state_q == FLUSH);
    assign BrBusy   = (state_q == FLUSH);
    assign TakenCnt = cnt_q;

endmodule

`default_nettype wire
